// File: rtl/pipe_exe_div_pkg.sv
// Shared definitions for the EXE-stage iterative divider.
//   DIV_WIDTH    default operand/result width
//   DIV_LATENCY  clock edges from accepted start to the edge that raises done, counted inclusively
//   RST_ENABLED  level of rst that holds the block in reset
//   STOP         level of busy that stalls the pipeline
//   div_state_e  divider control states
package pipe_exe_div_pkg;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;
  localparam logic        RST_ENABLED = 1'b1;
  localparam logic        STOP        = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/pipe_exe_div_if.sv
// Request/result bundle between the ID/EXE register and the divider.
//   master: start, sign, cancel, dividend, divisor out; busy, done, quotient, remainder in
//   slave : the mirror image, used by the divider
interface pipe_exe_div_if
  import pipe_exe_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic             sign;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, sign, cancel, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, sign, cancel, dividend, divisor,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/pipe_exe_div_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixes.
//   i_val    value to pass through or negate
//   i_neg    1 = output the two's complement of i_val
//   o_res_c  combinational result
module pipe_exe_div_abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_res_c
);

  assign o_res_c = i_neg ? (WIDTH'(0) - i_val) : i_val;

endmodule

// File: rtl/pipe_exe_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// Quotient goes to LO, remainder to HI; busy stalls the pipeline while the divider runs.
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of pipe_exe_div_if:
//             start/sign/dividend/divisor request, cancel flush,
//             busy stall, done pulse, quotient/remainder results
// Build option: define DIV_EARLY_OUT_EN to skip the iterations when the divisor is zero
// or the dividend magnitude is below the divisor magnitude.
module pipe_exe_div
  import pipe_exe_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  pipe_exe_div_if.slave      bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_wq, w_wq_nxt;       // working quotient, starts as |dividend|
  logic [WIDTH-1:0] r_wr, w_wr_nxt;       // working partial remainder
  logic [WIDTH-1:0] r_dvs, w_dvs_nxt;     // |divisor|
  logic             r_neg_q, w_neg_q_nxt;
  logic             r_neg_r, w_neg_r_nxt;
  logic             r_dz, w_dz_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_quo, w_quo_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;

  logic             w_dvd_neg, w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs;
  logic [WIDTH-1:0] w_quo_fix, w_rem_fix;
  logic [WIDTH:0]   w_rem_sh, w_trial;

  assign w_dvd_neg = bus.sign & bus.dividend[WIDTH-1];
  assign w_dvs_neg = bus.sign & bus.divisor[WIDTH-1];

  pipe_exe_div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (.i_val(bus.dividend), .i_neg(w_dvd_neg), .o_res_c(w_dvd_abs));
  pipe_exe_div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (.i_val(bus.divisor),  .i_neg(w_dvs_neg), .o_res_c(w_dvs_abs));
  pipe_exe_div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (.i_val(r_wq),         .i_neg(r_neg_q),   .o_res_c(w_quo_fix));
  pipe_exe_div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (.i_val(r_wr),         .i_neg(r_neg_r),   .o_res_c(w_rem_fix));

  // One restoring step: shift {rem,quo} left, trial-subtract |divisor| in WIDTH+1 bits.
  assign w_rem_sh = {r_wr, r_wq[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wq_nxt    = r_wq;
    w_wr_nxt    = r_wr;
    w_dvs_nxt   = r_dvs;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    w_dz_nxt    = r_dz;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;

    case (r_state)
      DIV_IDLE: begin
        if (bus.start && !bus.cancel) begin
          w_neg_q_nxt = w_dvd_neg ^ w_dvs_neg;
          w_neg_r_nxt = w_dvd_neg;
          w_dz_nxt    = (bus.divisor == '0);
          w_dvs_nxt   = w_dvs_abs;
          w_wq_nxt    = w_dvd_abs;
          w_wr_nxt    = '0;
          w_cnt_nxt   = CNT_W'(WIDTH - 1);
          w_busy_nxt  = STOP;
          w_state_nxt = DIV_RUN;
`ifdef DIV_EARLY_OUT_EN
          // Quotient is trivially zero (or forced later for divide-by-zero).
          if ((w_dvs_abs == '0) || (w_dvd_abs < w_dvs_abs)) begin
            w_wq_nxt    = '0;
            w_wr_nxt    = w_dvd_abs;
            w_state_nxt = DIV_FIX;
          end
`endif
        end
      end
      DIV_RUN: begin
        if (bus.cancel) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = DIV_IDLE;
        end else begin
          w_wq_nxt = {r_wq[WIDTH-2:0], ~w_trial[WIDTH]};
          w_wr_nxt = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
          if (r_cnt == '0) begin
            w_state_nxt = DIV_FIX;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      DIV_FIX: begin
        w_busy_nxt = 1'b0;
        if (bus.cancel) begin
          w_state_nxt = DIV_IDLE;
        end else begin
          // Divide-by-zero leaves |dividend| in the remainder, so the sign fix restores it raw.
          w_quo_nxt   = r_dz ? '1 : w_quo_fix;
          w_rem_nxt   = w_rem_fix;
          w_done_nxt  = 1'b1;
          w_state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        w_state_nxt = DIV_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLED) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_wq    <= '0;
      r_wr    <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wq    <= w_wq_nxt;
      r_wr    <= w_wr_nxt;
      r_dvs   <= w_dvs_nxt;
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
      r_dz    <= w_dz_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quo;
  assign bus.remainder = r_rem;

endmodule

// File: tb/tb_pipe_exe_div.sv
// Self-checking bench for pipe_exe_div: directed and random divisions against a
// plain-arithmetic reference, plus start-while-busy, cancel and reset cases.
module tb_pipe_exe_div;
  import pipe_exe_div_pkg::*;

  localparam int unsigned W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  localparam logic [31:0] DA [5] = '{32'd100, 32'hFFFF_FFF9, 32'd7,         32'h8000_0000, 32'd5};
  localparam logic [31:0] DB [5] = '{32'd7,   32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
  localparam logic        DS [5] = '{1'b0,    1'b1,          1'b1,          1'b1,          1'b0};
  localparam logic [31:0] EQ [5] = '{32'd14,  32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
  localparam logic [31:0] ER [5] = '{32'd2,   32'hFFFF_FFFF, 32'd1,         32'd0,         32'd5};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_exe_div_if #(.WIDTH(W)) bus ();
  pipe_exe_div #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_q, last_r;

  // Reference: quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, lq, lr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    lq = la / lb;
    lr = la % lb;
    return {lq[31:0], lr[31:0]};
  endfunction

  // Edges from the accepting edge through the edge that raises done, inclusive.
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb;
    bit early;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    early = (b == 32'd0) || (ma < mb);
    return (EO && early) ? 2 : int'(DIV_LATENCY);
  endfunction

  // Pulse start for one cycle from a negedge and wait (bounded) for done.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int edges, output int busy_cyc, output bit seen);
    bus.start = 1'b1; bus.sign = s; bus.dividend = a; bus.divisor = b; bus.cancel = 1'b0;
    edges = 0; busy_cyc = 0; seen = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk); bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.sign = 1'b0; bus.cancel = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
    n_checks++; if (bus.quotient !== 32'd0) begin n_errors++; $display("FAIL reset_q got %h want 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 32'd0) begin n_errors++; $display("FAIL reset_r got %h want 0", bus.remainder); end
    last_q = 32'd0; last_r = 32'd0;
  endtask

  task automatic test_directed;
    int edges, bc, lat;
    bit seen;
    for (int i = 0; i < 5; i++) begin
      lat = exp_lat(DA[i], DB[i], DS[i]);
      do_op(DA[i], DB[i], DS[i], edges, bc, seen);
      n_checks++; if (!seen) begin n_errors++; $display("FAIL dir%0d_done_timeout got none want pulse", i); end
      n_checks++; if (edges != lat) begin n_errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, edges, lat); end
      n_checks++; if (bc != lat - 1) begin n_errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, lat - 1); end
      n_checks++; if (bus.quotient !== EQ[i]) begin n_errors++; $display("FAIL dir%0d_q got %h want %h", i, bus.quotient, EQ[i]); end
      n_checks++; if (bus.remainder !== ER[i]) begin n_errors++; $display("FAIL dir%0d_r got %h want %h", i, bus.remainder, ER[i]); end
      last_q = EQ[i]; last_r = ER[i];
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int edges, bc, lat;
    bit seen;
    logic [31:0] a, b;
    logic s;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 1000));
        1: b = 32'd0 - 32'($urandom_range(1, 50));
        2: b = 32'd0;
        3: begin a = 32'($urandom_range(0, 60)); b = 32'($urandom_range(1, 100)); end
        default: ;
      endcase
      e = ref_div(a, b, s);
      lat = exp_lat(a, b, s);
      do_op(a, b, s, edges, bc, seen);
      n_checks++; if (!seen) begin n_errors++; $display("FAIL rnd%0d_done_timeout got none want pulse", i); end
      n_checks++; if (edges != lat) begin n_errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, edges, lat); end
      n_checks++; if (bus.quotient !== e[63:32]) begin n_errors++; $display("FAIL rnd%0d_q %h/%h s=%0b got %h want %h", i, a, b, s, bus.quotient, e[63:32]); end
      n_checks++; if (bus.remainder !== e[31:0]) begin n_errors++; $display("FAIL rnd%0d_r %h/%h s=%0b got %h want %h", i, a, b, s, bus.remainder, e[31:0]); end
      last_q = e[63:32]; last_r = e[31:0];
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored;
    int edges;
    bit seen;
    logic [63:0] e;
    e = ref_div(32'd1000, 32'd7, 1'b0);
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd7; bus.cancel = 1'b0;
    edges = 0; seen = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk);
      bus.start = (edges == 5);
      if (edges == 5) begin bus.sign = 1'b1; bus.dividend = 32'd55; bus.divisor = 32'd5; end
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    n_checks++; if (!seen || edges != int'(DIV_LATENCY)) begin n_errors++; $display("FAIL busy_start_latency got %0d want %0d", edges, DIV_LATENCY); end
    n_checks++; if (bus.quotient !== e[63:32]) begin n_errors++; $display("FAIL busy_start_q got %h want %h", bus.quotient, e[63:32]); end
    n_checks++; if (bus.remainder !== e[31:0]) begin n_errors++; $display("FAIL busy_start_r got %h want %h", bus.remainder, e[31:0]); end
    last_q = e[63:32]; last_r = e[31:0];
    @(negedge clk);
  endtask

  task automatic test_start_in_done;
    int edges, bc, n_done;
    bit seen;
    do_op(32'd999, 32'd10, 1'b0, edges, bc, seen);
    last_q = 32'd99; last_r = 32'd9;
    bus.start = 1'b1; bus.dividend = 32'd40; bus.divisor = 32'd3;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL done_start_busy got %0b want 0", bus.busy); end
    n_done = 0;
    repeat (40) begin @(negedge clk); if (bus.done === 1'b1) n_done++; end
    n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL done_start_pulses got %0d want 0", n_done); end
    n_checks++; if (bus.quotient !== last_q) begin n_errors++; $display("FAIL done_start_q got %h want %h", bus.quotient, last_q); end
  endtask

  task automatic test_cancel;
    int edges, bc, lat;
    bit seen;
    logic [63:0] e;
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd123456; bus.divisor = 32'd789; bus.cancel = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); bus.start = 1'b0; end
    bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.cancel = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL cancel_busy got %0b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL cancel_done got %0b want 0", bus.done); end
    n_checks++; if (bus.quotient !== last_q) begin n_errors++; $display("FAIL cancel_q_held got %h want %h", bus.quotient, last_q); end
    n_checks++; if (bus.remainder !== last_r) begin n_errors++; $display("FAIL cancel_r_held got %h want %h", bus.remainder, last_r); end
    e = ref_div(32'd77777, 32'hFFFF_FFF4, 1'b1);
    lat = exp_lat(32'd77777, 32'hFFFF_FFF4, 1'b1);
    do_op(32'd77777, 32'hFFFF_FFF4, 1'b1, edges, bc, seen);
    n_checks++; if (!seen || edges != lat) begin n_errors++; $display("FAIL post_cancel_latency got %0d want %0d", edges, lat); end
    n_checks++; if (bus.quotient !== e[63:32]) begin n_errors++; $display("FAIL post_cancel_q got %h want %h", bus.quotient, e[63:32]); end
    n_checks++; if (bus.remainder !== e[31:0]) begin n_errors++; $display("FAIL post_cancel_r got %h want %h", bus.remainder, e[31:0]); end
    last_q = e[63:32]; last_r = e[31:0];
    @(negedge clk);
  endtask

  task automatic test_cancel_with_start;
    int n_done;
    bus.start = 1'b1; bus.cancel = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd9; bus.divisor = 32'd2;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0; bus.cancel = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL cancel_start_busy got %0b want 0", bus.busy); end
    n_done = 0;
    repeat (40) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++; end
    n_checks++; if (n_done != 0) begin n_errors++; $display("FAIL cancel_start_activity got %0d want 0", n_done); end
  endtask

  task automatic test_rst_mid;
    int edges, bc;
    bit seen;
    bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.cancel = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); bus.start = 1'b0; end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy got %0b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL rst_mid_done got %0b want 0", bus.done); end
    n_checks++; if (bus.quotient !== 32'd0) begin n_errors++; $display("FAIL rst_mid_q got %h want 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 32'd0) begin n_errors++; $display("FAIL rst_mid_r got %h want 0", bus.remainder); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    do_op(32'd100, 32'd7, 1'b0, edges, bc, seen);
    n_checks++; if (!seen || bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
      n_errors++; $display("FAIL rst_recover got q=%h r=%h done=%0b want q=e r=2 done=1", bus.quotient, bus.remainder, seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_start_in_done();
    test_cancel();
    test_cancel_with_start();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
